// File: rtl/sgpr_pkg.sv
// Request/response types shared by the scalar issue front end and the SGPR file.
package sgpr_pkg;

  typedef enum logic [1:0] {
    sgpr_read  = 2'd0,
    sgpr_write = 2'd1
  } sgpr_op_t;

  typedef struct packed {
    sgpr_op_t         sgpr_op;
    logic [31:0]      base;
    logic [1:0][7:0]  addr;
    logic [63:0]      val;
    logic             scc;
  } sgpr_req_t;

  typedef struct packed {
    sgpr_op_t         sgpr_op;
    logic [1:0][63:0] val;
    logic             scc;
  } sgpr_resp_t;

  localparam int SGPR_REQ_SIZE  = $bits(sgpr_req_t);
  localparam int SGPR_RESP_SIZE = $bits(sgpr_resp_t);

endpackage

// File: rtl/sgpr_file.sv
// Scalar register file for one wave: valid/ready request channel, 2-port 64-bit reads,
// 64-bit pair writes, and an in-order 2-entry response queue.
module sgpr_file #(
  parameter int NUM_SGPR   = 128,
  parameter int RESP_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [sgpr_pkg::SGPR_REQ_SIZE-1:0] req,
  output logic                               resp_valid,
  input  logic                               resp_ready,
  output logic [sgpr_pkg::SGPR_RESP_SIZE-1:0] resp
);
  import sgpr_pkg::*;

  localparam int IDX_W = $clog2(NUM_SGPR);

  logic [31:0]      rf [NUM_SGPR];
  logic             scc_q;

  sgpr_req_t        rq_p0;
  logic [IDX_W-1:0] idx0_p0, idx0n_p0, idx1_p0, idx1n_p0;
  logic             is_wr_p0;
  logic             acc_p0;
  sgpr_resp_t       rnew_p0;

  sgpr_resp_t       head_p1, tail_p1;
  logic [1:0]       count_p1;
  logic             deq_p1;

  // Request decode: indices wrap modulo NUM_SGPR, unknown opcodes behave as reads.
  assign rq_p0    = sgpr_req_t'(req);
  assign idx0_p0  = IDX_W'(rq_p0.base + 32'(rq_p0.addr[0]));
  assign idx1_p0  = IDX_W'(rq_p0.base + 32'(rq_p0.addr[1]));
  assign idx0n_p0 = idx0_p0 + IDX_W'(1);
  assign idx1n_p0 = idx1_p0 + IDX_W'(1);
  assign is_wr_p0 = (rq_p0.sgpr_op == sgpr_write);

  assign req_ready = (count_p1 != 2'(RESP_DEPTH));
  assign acc_p0    = req_valid && req_ready;

  always_comb begin
    rnew_p0 = '0;
    if (is_wr_p0) begin
      rnew_p0.sgpr_op = sgpr_write;
      rnew_p0.scc     = rq_p0.scc;
    end else begin
      rnew_p0.sgpr_op = sgpr_read;
      rnew_p0.scc     = scc_q;
      rnew_p0.val[0]  = {rf[idx0n_p0], rf[idx0_p0]};
      rnew_p0.val[1]  = {rf[idx1n_p0], rf[idx1_p0]};
    end
  end

  // Commit stage: register file update and response queue (head/tail shift).
  assign resp_valid = (count_p1 != 2'd0);
  assign resp       = head_p1;
  assign deq_p1     = resp_valid && resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SGPR; i++) rf[i] <= '0;
      scc_q    <= 1'b0;
      head_p1  <= '0;
      tail_p1  <= '0;
      count_p1 <= 2'd0;
    end else begin
      if (acc_p0 && is_wr_p0) begin
        rf[idx0_p0]  <= rq_p0.val[31:0];
        rf[idx0n_p0] <= rq_p0.val[63:32];
        scc_q        <= rq_p0.scc;
      end
      // Head is cleared whenever the queue drains so resp reads 0 while empty.
      case ({acc_p0, deq_p1})
        2'b10: begin
          if (count_p1 == 2'd0) head_p1 <= rnew_p0;
          else                  tail_p1 <= rnew_p0;
          count_p1 <= count_p1 + 2'd1;
        end
        2'b01: begin
          head_p1  <= (count_p1 == 2'd2) ? tail_p1 : '0;
          tail_p1  <= '0;
          count_p1 <= count_p1 - 2'd1;
        end
        2'b11: begin
          if (count_p1 == 2'd1) begin
            head_p1 <= rnew_p0;
          end else begin
            head_p1 <= tail_p1;
            tail_p1 <= rnew_p0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
